// File: rtl/conv_tile_scheduler_if.sv
// Handshake and tile-coordinate bundle between the layer sequencer (master)
// and its surroundings: layer control, tile start/done, and tile bases.
interface conv_tile_scheduler_if #(
  parameter int AW = 32,
  parameter int CW = 16
);
  logic          conv_start;
  logic          conv_done;
  logic          busy;
  logic          tile_start;
  logic          tile_done;
  logic [AW-1:0] tile_base_n;
  logic [AW-1:0] tile_base_m;
  logic [AW-1:0] tile_base_row;
  logic [AW-1:0] tile_base_col;
  logic [CW-1:0] tile_idx;

  modport master (
    input  conv_start, tile_done,
    output conv_done, busy, tile_start,
           tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_idx
  );

  modport slave (
    output conv_start, tile_done,
    input  conv_done, busy, tile_start,
           tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_idx
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Layer tile sequencer: walks N x M x R x C in Tn x Tm x Tr x Tc tiles
// (m innermost, then n, col, row), one start/done handshake per tile.
module conv_tile_scheduler #(
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int N  = 32,
  parameter int M  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_tile_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [AW-1:0] N_LAST  = AW'(N - Tn);
  localparam logic [AW-1:0] M_LAST  = AW'(M - Tm);
  localparam logic [AW-1:0] R_LAST  = AW'(R - Tr);
  localparam logic [AW-1:0] C_LAST  = AW'(C - Tc);
  localparam logic [AW-1:0] N_STEP  = AW'(Tn);
  localparam logic [AW-1:0] M_STEP  = AW'(Tm);
  localparam logic [AW-1:0] R_STEP  = AW'(Tr);
  localparam logic [AW-1:0] C_STEP  = AW'(Tc);

  state_e        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] m_q, m_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [CW-1:0] idx_q, idx_d;

  logic m_wrap, n_wrap, col_wrap, row_wrap, last_tile;

  // Wrap is detected against (dimension - tile), never by counter overflow.
  assign m_wrap    = (m_q   == M_LAST);
  assign n_wrap    = (n_q   == N_LAST);
  assign col_wrap  = (col_q == C_LAST);
  assign row_wrap  = (row_q == R_LAST);
  assign last_tile = m_wrap && n_wrap && col_wrap && row_wrap;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        n_d   = '0;
        m_d   = '0;
        row_d = '0;
        col_d = '0;
        idx_d = '0;
        if (bus.conv_start) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.tile_done) begin
          if (last_tile) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            idx_d   = idx_q + CW'(1);
            // m innermost so input channels accumulate into one output tile.
            if (m_wrap) begin
              m_d = '0;
              if (n_wrap) begin
                n_d = '0;
                if (col_wrap) begin
                  col_d = '0;
                  row_d = row_q + R_STEP;
                end else begin
                  col_d = col_q + C_STEP;
                end
              end else begin
                n_d = n_q + N_STEP;
              end
            end else begin
              m_d = m_q + M_STEP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        n_d     = '0;
        m_d     = '0;
        row_d   = '0;
        col_d   = '0;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.tile_start    = (state_q == ISSUE);
  assign bus.conv_done     = (state_q == DONE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.tile_base_n   = n_q;
  assign bus.tile_base_m   = m_q;
  assign bus.tile_base_row = row_q;
  assign bus.tile_base_col = col_q;
  assign bus.tile_idx      = idx_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench: default-parameter layer walk plus a single-tile instance.
module tb_conv_tile_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_first, t_done;

  int exp_n[8]   = '{0, 0, 16, 16, 0, 0, 16, 16};
  int exp_m[8]   = '{0, 16, 0, 16, 0, 16, 0, 16};
  int exp_col[8] = '{0, 0, 0, 0, 16, 16, 16, 16};

  always #5 clk = ~clk;

  conv_tile_scheduler_if #(.AW(32), .CW(16)) ifc ();
  conv_tile_scheduler_if #(.AW(32), .CW(16)) ifc2 ();

  conv_tile_scheduler dut (.clk(clk), .rst(rst), .bus(ifc));

  conv_tile_scheduler #(
    .N(16), .M(16), .R(64), .C(16), .Tn(16), .Tm(16), .Tr(64), .Tc(16)
  ) dut1 (.clk(clk), .rst(rst), .bus(ifc2));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(ifc.busy), 32'd0);
    chk({tag, ".start"}, 32'(ifc.tile_start), 32'd0);
    chk({tag, ".cdone"}, 32'(ifc.conv_done), 32'd0);
    chk({tag, ".n"},     ifc.tile_base_n, 32'd0);
    chk({tag, ".m"},     ifc.tile_base_m, 32'd0);
    chk({tag, ".row"},   ifc.tile_base_row, 32'd0);
    chk({tag, ".col"},   ifc.tile_base_col, 32'd0);
    chk({tag, ".idx"},   32'(ifc.tile_idx), 32'd0);
  endtask

  task automatic chk_tile(input string tag, input int t);
    chk({tag, ".start"}, 32'(ifc.tile_start), 32'd1);
    chk({tag, ".busy"},  32'(ifc.busy), 32'd1);
    chk({tag, ".n"},     ifc.tile_base_n, 32'(exp_n[t]));
    chk({tag, ".m"},     ifc.tile_base_m, 32'(exp_m[t]));
    chk({tag, ".row"},   ifc.tile_base_row, 32'd0);
    chk({tag, ".col"},   ifc.tile_base_col, 32'(exp_col[t]));
    chk({tag, ".idx"},   32'(ifc.tile_idx), 32'(t));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.conv_start  = 1'b0;
    ifc.tile_done   = 1'b0;
    ifc2.conv_start = 1'b0;
    ifc2.tile_done  = 1'b0;
    tick();
    tick();
    chk_zero("reset_hold");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // Stray tile_done in IDLE must not start anything.
    ifc.tile_done = 1'b1;
    tick();
    ifc.tile_done = 1'b0;
    chk("idle_done.start", 32'(ifc.tile_start), 32'd0);
    chk("idle_done.busy",  32'(ifc.busy), 32'd0);

    // Layer A: minimum-latency engine, stray conv_start during WAIT.
    ifc.conv_start = 1'b1;
    tick();
    ifc.conv_start = 1'b0;
    t_first = cyc;
    for (int t = 0; t < 8; t++) begin
      chk_tile($sformatf("walk%0d", t), t);
      tick();
      chk($sformatf("wait%0d.start", t), 32'(ifc.tile_start), 32'd0);
      chk($sformatf("wait%0d.cdone", t), 32'(ifc.conv_done), 32'd0);
      ifc.tile_done = 1'b1;
      if (t == 3) ifc.conv_start = 1'b1;
      tick();
      ifc.tile_done  = 1'b0;
      ifc.conv_start = 1'b0;
    end
    t_done = cyc;
    chk("done.cdone", 32'(ifc.conv_done), 32'd1);
    chk("done.busy",  32'(ifc.busy), 32'd1);
    chk("done.start", 32'(ifc.tile_start), 32'd0);
    chk("done.latency", 32'(t_done - t_first), 32'd16);
    tick();
    chk_zero("after_done");

    // Layer B starts at the earliest legal edge.
    ifc.conv_start = 1'b1;
    tick();
    ifc.conv_start = 1'b0;
    chk_tile("b0", 0);
    ifc.tile_done = 1'b1;
    tick();
    ifc.tile_done = 1'b0;
    chk("issue_done.start", 32'(ifc.tile_start), 32'd0);
    chk("issue_done.busy",  32'(ifc.busy), 32'd1);
    tick();
    chk("issue_done.hold_start", 32'(ifc.tile_start), 32'd0);
    chk("issue_done.hold_idx",   32'(ifc.tile_idx), 32'd0);
    ifc.tile_done = 1'b1;
    tick();
    ifc.tile_done = 1'b0;
    for (int t = 1; t < 3; t++) begin
      chk_tile($sformatf("b%0d", t), t);
      tick();
      tick();
      ifc.tile_done = 1'b1;
      tick();
      ifc.tile_done = 1'b0;
    end
    chk_tile("b3", 3);

    // Asynchronous reset mid-cycle, mid-layer.
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    rst = 1'b0;
    chk_zero("rst_release");
    ifc.conv_start = 1'b1;
    tick();
    ifc.conv_start = 1'b0;
    chk_tile("restart", 0);

    // Single-tile layer.
    ifc2.conv_start = 1'b1;
    tick();
    ifc2.conv_start = 1'b0;
    chk("one.start", 32'(ifc2.tile_start), 32'd1);
    chk("one.idx",   32'(ifc2.tile_idx), 32'd0);
    tick();
    chk("one.wait_start", 32'(ifc2.tile_start), 32'd0);
    ifc2.tile_done = 1'b1;
    tick();
    ifc2.tile_done = 1'b0;
    chk("one.cdone", 32'(ifc2.conv_done), 32'd1);
    chk("one.idx_done", 32'(ifc2.tile_idx), 32'd0);
    chk("one.start_done", 32'(ifc2.tile_start), 32'd0);
    tick();
    chk("one.cdone_off", 32'(ifc2.conv_done), 32'd0);
    chk("one.busy_off",  32'(ifc2.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Layer-level tile sequencer that sits directly upstream of the convolution tile engine. It walks the full N×M×R×C layer in Tn×Tm×Tr×Tc tiles. For each tile it drives the four tile base coordinates, issues a one-cycle tile start, and waits for the engine's tile done before moving on. After the last tile completes it pulses a layer-done signal.

## Interface
Parameters
- AW, 32, width of tile base coordinate outputs
- CW, 16, width of tile index counter
- N, 32, total output channels
- M, 32, total input channels
- R, 64, total feature rows
- C, 32, total feature columns
- Tn, 16, output-channel tile size; N % Tn == 0 required
- Tm, 16, input-channel tile size; M % Tm == 0 required
- Tr, 64, row tile size; R % Tr == 0 required
- Tc, 16, column tile size; C % Tc == 0 required

Ports
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- conv_start  in  1  layer start pulse; sampled only in IDLE
- conv_done  out  1  one-cycle pulse after the last tile's done
- busy  out  1  high in every state except IDLE
- tile_start  out  1  one-cycle pulse per tile; drives the engine's tile start
- tile_done  in  1  engine tile-done pulse; honoured only in WAIT
- tile_base_n  out  AW  output-channel base of the current tile
- tile_base_m  out  AW  input-channel base of the current tile
- tile_base_row  out  AW  row base of the current tile
- tile_base_col  out  AW  column base of the current tile
- tile_idx  out  CW  zero-based index of the current tile

## Operation
- **States**
  - IDLE: conv_start → ISSUE; all bases and tile_idx cleared to 0.
  - ISSUE: tile_start=1 for exactly one cycle; → WAIT.
  - WAIT: on tile_done, if the current tile is the last one → DONE; otherwise → ISSUE, advancing the counters on the same edge.
  - DONE: conv_done=1 for one cycle; → IDLE.
- **Loop order**: m is innermost, then n, then col; row is outermost.
  - Input channels accumulate consecutively into the same output tile.
  - tile_base_m steps by Tm and wraps to 0 at M, carrying into n.
  - tile_base_n steps by Tn and wraps at N, carrying into col.
  - tile_base_col steps by Tc and wraps at C, carrying into row.
  - tile_base_row steps by Tr.
- **Last tile**: m=M-Tm, n=N-Tn, col=C-Tc and row=R-Tr, all true together.
- **Tile count**: total tiles T = (N/Tn)(M/Tm)(R/Tr)(C/Tc); T must fit in CW bits.
  - tile_idx increments with every advance, so it equals the tile ordinal.
- **Arithmetic**: all base counters are unsigned AW-bit values.
  - Wrap is detected by comparing against the dimension minus the tile size, not by overflow.
- **Base stability**: bases are registered and change only on the ISSUE-entry edge, so they are stable from ISSUE through WAIT.
  - The downstream engine samples them at its start and during its whole load and store phase.
- **Ignored inputs**
  - conv_start outside IDLE is ignored; no restart and no queuing.
  - tile_done outside WAIT is ignored, including a stray pulse in ISSUE.
- **Reset**: asynchronous rst at any time, including mid-layer, forces IDLE immediately.
  - All outputs go to 0: conv_done, busy, tile_start, every tile_base_*, tile_idx.
  - No pending pulse survives reset.

## Timing
- conv_start is sampled high at edge k. In the cycle after edge k:
  - tile_start=1 with bases (0,0,0,0), busy=1.
  - tile_start is low again after edge k+1.
- tile_done is sampled high at edge u for a non-last tile:
  - the next tile's bases appear after edge u;
  - tile_start=1 for that same cycle (u to u+1).
- Tile-to-tile overhead is 1 cycle from tile_done to the next tile_start.
- tile_done is sampled high at edge u for the last tile:
  - conv_done=1 in cycle u to u+1 and busy stays 1 in that cycle;
  - IDLE and busy=0 follow after edge u+1.
- Earliest next layer start: conv_start can be accepted at edge u+2.
- tile_done is allowed in the very first WAIT cycle; the minimum engine latency is 1 cycle.

## Test plan
- **Reset defaults**: assert rst asynchronously mid-cycle → all outputs 0 before the next edge, state IDLE.
- **Default parameters, full walk**: T=8. Required (n,m,row,col) sequence, with tile_idx 0..7 and exactly one conv_done after the 8th tile_done:
  - (0,0,0,0), (0,16,0,0), (16,0,0,0), (16,16,0,0)
  - (0,0,0,16), (0,16,0,16), (16,0,0,16), (16,16,0,16)
- **Minimum-latency engine**: tile_done returned 1 cycle after each tile_start → tile_start period of 2 cycles; conv_done 16 cycles after the first tile_start.
- **Spurious inputs**:
  - conv_start during WAIT → no effect on the sequence.
  - tile_done during IDLE → no tile_start.
  - tile_done coincident with tile_start (ISSUE) → ignored; the bench stays in WAIT until the next tile_done.
- **Reset mid-layer**: assert rst after the 3rd tile_done → immediate IDLE with bases 0. A subsequent conv_start restarts at (0,0,0,0), tile_idx 0.
- **Degenerate single tile (N=Tn, M=Tm, R=Tr, C=Tc)**: conv_start → one tile_start → tile_done → conv_done the next cycle; tile_idx stays 0.
